// File: rtl/debug_snapshot_pkg.sv
// Shared types, constants and helpers for the debug snapshot buffer.
package debug_snapshot_pkg;

  localparam int unsigned DefaultWordWidth = 32;
  localparam int unsigned DefaultNumWords  = 12;

  // Word positions of the pipeline fields inside one snapshot
  localparam int unsigned WordPcCycle     = 0;
  localparam int unsigned WordAdderBranch = 1;
  localparam int unsigned WordIfInstr     = 2;
  localparam int unsigned WordDataA       = 3;
  localparam int unsigned WordDataB       = 4;
  localparam int unsigned WordSignExtImm  = 5;
  localparam int unsigned WordIdCtrl      = 6;
  localparam int unsigned WordAluResult   = 7;
  localparam int unsigned WordStoreData   = 8;
  localparam int unsigned WordExCtrl      = 9;
  localparam int unsigned WordMemReadData = 10;
  localparam int unsigned WordWbCtrl      = 11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StStream = 2'd2
  } state_e;

  // Bits needed to index `value` items; never less than one bit
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/debug_snapshot_buffer_if.sv
// Read-request and word-stream handshake between the buffer and the debug UART.
interface debug_snapshot_buffer_if #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 3
);
  logic                  i_read_req;
  logic [IDX_WIDTH-1:0]  i_read_index;
  logic                  o_read_ack;
  logic                  o_error;
  logic                  o_valid;
  logic                  i_ready;
  logic [WORD_WIDTH-1:0] o_data;
  logic                  o_last;

  modport master (
    output i_read_req, i_read_index, i_ready,
    input  o_read_ack, o_error, o_valid, o_data, o_last
  );

  modport slave (
    input  i_read_req, i_read_index, i_ready,
    output o_read_ack, o_error, o_valid, o_data, o_last
  );
endinterface

// File: rtl/snapshot_serializer.sv
// Holds a shadow copy of one snapshot and streams it out word by word.
module snapshot_serializer
  import debug_snapshot_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DefaultWordWidth,
  parameter int unsigned NUM_WORDS  = DefaultNumWords,
  localparam int unsigned CntW      = clog2(NUM_WORDS)
) (
  input  logic                            i_clock,
  input  logic                            i_soft_reset,
  input  logic                            i_load,
  input  logic                            i_abort,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] i_snapshot,
  input  logic                            i_ready,
  output logic                            o_valid,
  output logic [WORD_WIDTH-1:0]           o_data,
  output logic                            o_last,
  output logic                            o_done
);

  logic [WORD_WIDTH-1:0] shadow_q [NUM_WORDS];
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_nxt;
  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;

  // Shadow copy taken from the memory word selected in the load cycle
  always_ff @(posedge i_clock) begin
    if (i_load) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        shadow_q[k] <= i_snapshot[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Next word/handshake state; pend_q gives the shadow one cycle before word 0 is presented
  always_comb begin
    cnt_nxt = cnt_q + CntW'(1);
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    o_done  = valid_q & i_ready & last_q;
    if (i_abort) begin
      cnt_d   = '0;
      pend_d  = 1'b0;
      valid_d = 1'b0;
      data_d  = '0;
      last_d  = 1'b0;
    end else if (i_load) begin
      cnt_d   = '0;
      pend_d  = 1'b1;
      valid_d = 1'b0;
      data_d  = '0;
      last_d  = 1'b0;
    end else if (pend_q) begin
      pend_d  = 1'b0;
      valid_d = 1'b1;
      data_d  = shadow_q[0];
      last_d  = (NUM_WORDS == 1);
    end else if (valid_q && i_ready) begin
      if (last_q) begin
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt_nxt;
        data_d = shadow_q[cnt_nxt];
        last_d = (cnt_nxt == CntW'(NUM_WORDS - 1));
      end
    end
  end

  // Counter and registered outputs
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

endmodule

// File: rtl/debug_snapshot_buffer.sv
// Circular history of pipeline snapshots with age-indexed streamed readout.
module debug_snapshot_buffer
  import debug_snapshot_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = DefaultWordWidth,
  parameter int unsigned NUM_WORDS      = DefaultNumWords,
  parameter int unsigned DEPTH          = 8,
  parameter bit          FREEZE_ON_HALT = 1'b1,
  localparam int unsigned IdxW          = clog2(DEPTH),
  localparam int unsigned CntW          = clog2(DEPTH + 1)
) (
  input  logic                            i_clock,
  input  logic                            i_soft_reset,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] i_snapshot,
  input  logic                            i_capture,
  input  logic                            i_halt,
  input  logic                            i_clear,
  debug_snapshot_buffer_if.slave          rd,
  output logic [CntW-1:0]                 o_count,
  output logic                            o_wrapped,
  output logic                            o_frozen
);

  logic [NUM_WORDS*WORD_WIDTH-1:0] mem_q [DEPTH];

  state_e          state_q, state_d;
  logic [IdxW-1:0] wr_ptr_q, wr_ptr_d, addr_q, addr_d;
  logic [IdxW:0]   addr_sum;
  logic [CntW-1:0] count_q, count_d;
  logic            wrapped_q, wrapped_d, frozen_q, frozen_d;
  logic            ack_q, ack_d, err_q, err_d;
  logic            cap, load, ser_done;
  logic            ser_valid, ser_last;
  logic [WORD_WIDTH-1:0] ser_data;

  // History storage; contents are not reset
  always_ff @(posedge i_clock) begin
    if (cap) mem_q[wr_ptr_q] <= i_snapshot;
  end

  // Capture bookkeeping, request decode and FSM next state
  always_comb begin
    cap       = i_capture & ~frozen_q & ~i_clear;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    frozen_d  = frozen_q;
    state_d   = state_q;
    addr_d    = addr_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    load      = 1'b0;
    // Age 0 is the slot just behind the write pointer; wrap explicitly for non-power-of-two depth
    addr_sum  = (IdxW+1)'(wr_ptr_q) + (IdxW+1)'(DEPTH - 1) - (IdxW+1)'(rd.i_read_index);
    if (addr_sum >= (IdxW+1)'(DEPTH)) addr_sum = addr_sum - (IdxW+1)'(DEPTH);

    if (cap) begin
      wr_ptr_d = (wr_ptr_q == IdxW'(DEPTH - 1)) ? '0 : wr_ptr_q + IdxW'(1);
      if (count_q < CntW'(DEPTH)) count_d = count_q + CntW'(1);
      else                        wrapped_d = 1'b1;
      if (FREEZE_ON_HALT && i_halt) frozen_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // ack_q blocks re-decoding a request still held in the cycle its ack is visible
        if (rd.i_read_req && !ack_q && !cap && !i_clear) begin
          ack_d = 1'b1;
          if (CntW'(rd.i_read_index) < count_q) begin
            addr_d  = addr_sum[IdxW-1:0];
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        load    = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (ser_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (i_clear) begin
      wr_ptr_d  = '0;
      count_d   = '0;
      wrapped_d = 1'b0;
      frozen_d  = 1'b0;
      state_d   = StIdle;
      load      = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      frozen_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      frozen_q  <= frozen_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  snapshot_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_serializer (
    .i_clock      (i_clock),
    .i_soft_reset (i_soft_reset),
    .i_load       (load),
    .i_abort      (i_clear),
    .i_snapshot   (mem_q[addr_q]),
    .i_ready      (rd.i_ready),
    .o_valid      (ser_valid),
    .o_data       (ser_data),
    .o_last       (ser_last),
    .o_done       (ser_done)
  );

  assign rd.o_valid    = ser_valid;
  assign rd.o_data     = ser_data;
  assign rd.o_last     = ser_last;
  assign rd.o_read_ack = ack_q;
  assign rd.o_error    = err_q;
  assign o_count       = count_q;
  assign o_wrapped     = wrapped_q;
  assign o_frozen      = frozen_q;

endmodule

// File: tb/tb_debug_snapshot_buffer.sv
// Directed scoreboard bench for debug_snapshot_buffer (4 words x 4 entries).
module tb_debug_snapshot_buffer;

  localparam int unsigned WW = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned DP = 4;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } word_t;

  logic             clk;
  logic             rst_n;
  logic [NW*WW-1:0] snapshot;
  logic             capture, halt, clear;
  logic [2:0]       count;
  logic             wrapped, frozen;

  int    n_checks = 0;
  int    n_errors = 0;
  word_t exp_q[$];

  debug_snapshot_buffer_if #(.WORD_WIDTH(WW), .IDX_WIDTH(2)) rd ();

  debug_snapshot_buffer #(
    .WORD_WIDTH     (WW),
    .NUM_WORDS      (NW),
    .DEPTH          (DP),
    .FREEZE_ON_HALT (1'b1)
  ) dut (
    .i_clock      (clk),
    .i_soft_reset (rst_n),
    .i_snapshot   (snapshot),
    .i_capture    (capture),
    .i_halt       (halt),
    .i_clear      (clear),
    .rd           (rd.slave),
    .o_count      (count),
    .o_wrapped    (wrapped),
    .o_frozen     (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NW*WW-1:0] make_snap(input logic [WW-1:0] base);
    logic [NW*WW-1:0] s;
    for (int k = 0; k < NW; k++) s[k*WW +: WW] = base + WW'(k);
    return s;
  endfunction

  function automatic void push_exp(input logic [WW-1:0] base);
    for (int k = 0; k < NW; k++) exp_q.push_back('{data: base + WW'(k), last: (k == NW - 1)});
  endfunction

  // Monitor: pops the scoreboard on each handshake, checks hold and idle-zero outputs
  initial begin
    logic          hold_pend;
    logic [WW-1:0] hold_data;
    logic          hold_last;
    word_t         e;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_pend && rd.o_valid) begin
        check("hold_data", rd.o_data, hold_data);
        check("hold_last", rd.o_last, hold_last);
      end
      hold_pend = 1'b0;
      if (!rd.o_valid) begin
        check("idle_data_last_zero", {rd.o_data, rd.o_last}, '0);
      end else if (!rd.i_ready) begin
        hold_pend = 1'b1;
        hold_data = rd.o_data;
        hold_last = rd.o_last;
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0h expected no word", rd.o_data);
      end else begin
        e = exp_q.pop_front();
        check("stream_data", rd.o_data, e.data);
        check("stream_last", rd.o_last, e.last);
      end
    end
  end

  task automatic do_capture(input logic [WW-1:0] base, input logic h);
    snapshot = make_snap(base);
    capture  = 1'b1;
    halt     = h;
    @(posedge clk); #1;
    capture  = 1'b0;
    halt     = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (rd.o_read_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Checks from ack onwards: latency, full drain, valid dropping after the last word
  task automatic finish_read(input bit exp_err);
    bit drained;
    check("error_flag", rd.o_error, exp_err);
    if (exp_err) begin
      check("err_no_valid", rd.o_valid, 1'b0);
      @(posedge clk); #1;
      check("ack_is_pulse", {rd.o_read_ack, rd.o_error}, 2'b00);
    end else begin
      @(posedge clk); #1;
      check("valid_lat1", rd.o_valid, 1'b0);
      @(posedge clk); #1;
      check("valid_lat2", rd.o_valid, 1'b1);
      drained = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (exp_q.size() == 0) begin
          drained = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      check("stream_drained", drained, 1'b1);
      check("valid_after_last", rd.o_valid, 1'b0);
    end
  endtask

  task automatic do_read(input logic [1:0] idx, input bit exp_err, input logic [WW-1:0] base);
    bit got;
    if (!exp_err) push_exp(base);
    rd.i_read_req   = 1'b1;
    rd.i_read_index = idx;
    wait_ack(got);
    rd.i_read_req   = 1'b0;
    check("read_ack", got, 1'b1);
    finish_read(exp_err);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    rst_n           = 1'b0;
    snapshot        = '0;
    capture         = 1'b0;
    halt            = 1'b0;
    clear           = 1'b0;
    rd.i_read_req   = 1'b0;
    rd.i_read_index = '0;
    rd.i_ready      = 1'b1;
    #12;
    check("reset_outputs", {rd.o_read_ack, rd.o_error, rd.o_valid, rd.o_data, rd.o_last,
                            count, wrapped, frozen}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty history: read is rejected
    do_read(2'd0, 1'b1, '0);
    check("count_empty", count, 3'd0);

    // Two captures, oldest read back
    do_capture(32'h10, 1'b0);
    do_capture(32'h20, 1'b0);
    check("count_two", count, 3'd2);
    do_read(2'd1, 1'b0, 32'h10);

    // Overwrite: six captures into four slots
    do_clear();
    for (int i = 0; i < 6; i++) do_capture(32'h100 + 32'(i) * 32'h10, 1'b0);
    check("count_sat", count, 3'd4);
    check("wrapped_set", wrapped, 1'b1);
    do_read(2'd3, 1'b0, 32'h120);
    do_read(2'd0, 1'b0, 32'h150);

    // Back-pressure with captures every cycle during load and stream
    do_clear();
    do_capture(32'h200, 1'b0);
    push_exp(32'h200);
    rd.i_read_req   = 1'b1;
    rd.i_read_index = 2'd0;
    wait_ack(got);
    rd.i_read_req   = 1'b0;
    check("read_ack_bp", got, 1'b1);
    fork
      finish_read(1'b0);
      begin
        for (int i = 0; i < 12; i++) begin
          rd.i_ready = (i % 4 == 0) || (i % 4 == 3);
          snapshot   = make_snap(32'h300 + 32'(i) * 32'h10);
          capture    = 1'b1;
          @(posedge clk); #1;
          check("count_bp", count, (i + 2 > 4) ? 3'd4 : 3'(i + 2));
        end
        capture    = 1'b0;
        rd.i_ready = 1'b1;
      end
    join
    check("wrapped_bp", wrapped, 1'b1);

    // Freeze on halt: later captures ignored
    do_capture(32'h400, 1'b1);
    for (int i = 0; i < 3; i++) do_capture(32'h500 + 32'(i) * 32'h10, 1'b0);
    check("frozen_set", frozen, 1'b1);
    check("count_frozen", count, 3'd4);
    do_read(2'd0, 1'b0, 32'h400);
    do_clear();
    check("clear_flags", {count, frozen, wrapped}, 5'd0);

    // Request coinciding with a capture is deferred by one cycle
    do_capture(32'h600, 1'b0);
    push_exp(32'h700);
    snapshot        = make_snap(32'h700);
    capture         = 1'b1;
    rd.i_read_req   = 1'b1;
    rd.i_read_index = 2'd0;
    @(posedge clk); #1;
    capture = 1'b0;
    check("deferred_no_ack", rd.o_read_ack, 1'b0);
    @(posedge clk); #1;
    check("deferred_ack", rd.o_read_ack, 1'b1);
    rd.i_read_req = 1'b0;
    check("deferred_no_err", rd.o_error, 1'b0);
    // Two more edges reach word 0; one more takes it, then reset mid-stream
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("deferred_valid", rd.o_valid, 1'b1);
    @(posedge clk); #1;
    check("count_pre_rst", count, 3'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {rd.o_read_ack, rd.o_error, rd.o_valid, rd.o_data, rd.o_last,
                          count, wrapped, frozen}, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
